// File: rtl/polyphase_interp_2.sv
// Two-phase polyphase interpolate-by-2 FIR: one input sample in, an even-phase
// and then an odd-phase output sample out, using shift-add constant multiplies.
module polyphase_interp_2 #(
  parameter int word_size_in  = 8,
  parameter int word_size_out = 20
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            X_valid,
  output logic                            X_ready,
  input  logic signed [word_size_in-1:0]  X,
  output logic                            Y_valid,
  output logic                            Y_phase,
  output logic signed [word_size_out-1:0] Y
);

  localparam int NUM_TAPS = 11;
  localparam int EVEN_COEF [NUM_TAPS] = '{-1, 4, 3, -37, 64, 249, 147, -27, -12, 9, -1};
  localparam int ODD_COEF  [NUM_TAPS] = '{0, 9, -19, -16, 174, 237, 39, -35, 6, 3, 0};

  typedef enum logic [1:0] {IDLE, EVEN, ODD} state_t;

  state_t                           r_state;
  state_t                           w_stateNext;
  logic signed [word_size_in-1:0]   r_delay [NUM_TAPS];
  logic signed [word_size_out-1:0]  r_y;
  logic                             r_yValid;
  logic                             r_yPhase;
  logic                             w_accept;
  logic signed [word_size_out-1:0]  w_yEven;
  logic signed [word_size_out-1:0]  w_yOdd;

  // Constant coefficient folds the loop down to a handful of shifted adds.
  function automatic logic signed [word_size_out-1:0] constMul(
    input logic signed [word_size_out-1:0] x,
    input int                              c
  );
    logic signed [word_size_out-1:0] acc;
    int mag;
    acc = '0;
    mag = (c < 0) ? -c : c;
    for (int b = 0; b < 9; b++) begin
      if (mag[b]) acc = acc + (x <<< b);
    end
    return (c < 0) ? -acc : acc;
  endfunction

  always_comb begin
    w_yEven = '0;
    w_yOdd  = '0;
    for (int k = 0; k < NUM_TAPS; k++) begin
      w_yEven = w_yEven + constMul(word_size_out'(r_delay[k]), EVEN_COEF[k]);
      w_yOdd  = w_yOdd  + constMul(word_size_out'(r_delay[k]), ODD_COEF[k]);
    end
  end

  always_comb begin
    w_stateNext = r_state;
    X_ready     = 1'b0;
    case (r_state)
      IDLE: begin
        X_ready = ~reset;
        if (X_valid && !reset) w_stateNext = EVEN;
      end
      EVEN: begin
        w_stateNext = ODD;
      end
      ODD: begin
        X_ready     = ~reset;
        w_stateNext = (X_valid && !reset) ? EVEN : IDLE;
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  assign w_accept = X_valid & X_ready;

  // The odd sample is taken from the delay line as it was before this cycle's shift.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_y      <= '0;
      r_yValid <= 1'b0;
      r_yPhase <= 1'b0;
      for (int k = 0; k < NUM_TAPS; k++) r_delay[k] <= '0;
    end else begin
      r_state <= w_stateNext;
      if (w_accept) begin
        r_delay[0] <= X;
        for (int k = 1; k < NUM_TAPS; k++) r_delay[k] <= r_delay[k-1];
      end
      case (r_state)
        EVEN: begin
          r_y      <= w_yEven;
          r_yPhase <= 1'b0;
          r_yValid <= 1'b1;
        end
        ODD: begin
          r_y      <= w_yOdd;
          r_yPhase <= 1'b1;
          r_yValid <= 1'b1;
        end
        default: begin
          r_yValid <= 1'b0;
        end
      endcase
    end
  end

  assign Y       = r_y;
  assign Y_valid = r_yValid;
  assign Y_phase = r_yPhase;

endmodule

// File: tb/tb_polyphase_interp_2.sv
// Self-checking bench for polyphase_interp_2: directed impulse/step/handshake/reset
// tests plus random traffic, all compared against a cycle-level behavioural model.
module tb_polyphase_interp_2;

  localparam int WI   = 8;
  localparam int WO   = 20;
  localparam int NCYC = 4096;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 X_valid = 1'b0;
  logic signed [WI-1:0] X = '0;
  logic                 X_ready;
  logic                 Y_valid;
  logic                 Y_phase;
  logic signed [WO-1:0] Y;

  polyphase_interp_2 #(.word_size_in(WI), .word_size_out(WO)) dut (
    .clk     (clk),
    .reset   (reset),
    .X_valid (X_valid),
    .X_ready (X_ready),
    .X       (X),
    .Y_valid (Y_valid),
    .Y_phase (Y_phase),
    .Y       (Y)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int h [21] = '{-1, 0, 4, 9, 3, -19, -37, -16, 64, 174, 249, 237, 147, 39, -27, -35, -12, 6, 9, 3, -1};

  int  hist [$];
  int  capY [$];
  int  capPh [$];
  bit  dueV [NCYC];
  int  dueY [NCYC];
  bit  dueP [NCYC];
  int  cyc = 0;
  bit  enabled = 0;
  bit  prevReset = 0;
  bit  prevAccept = 0;
  int  expY = 0;
  bit  expPh = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Interpolated output n uses the newest 11 samples: even taps h[2k], odd taps h[2k+1].
  function automatic int modelOut(input bit odd);
    int acc;
    int idx;
    acc = 0;
    for (int k = 0; k < 11; k++) begin
      idx = odd ? 2 * k + 1 : 2 * k;
      if (k < hist.size() && idx < 21) acc += h[idx] * hist[k];
    end
    return acc;
  endfunction

  // Compare process: outputs for cycle cyc, then fold this cycle's inputs into the model.
  always @(negedge clk) begin
    bit expV;
    bit expR;
    expR = !reset && !prevAccept;
    if (enabled) begin
      if (prevReset) begin
        expY = 0; expPh = 0; expV = 0;
      end else if (dueV[cyc]) begin
        expY = dueY[cyc]; expPh = dueP[cyc]; expV = 1;
      end else begin
        expV = 0;
      end
      checkOutput("Y_valid", int'(Y_valid), int'(expV));
      checkOutput("X_ready", int'(X_ready), int'(expR));
      checkOutput("Y", int'($signed(Y)), expY);
      checkOutput("Y_phase", int'(Y_phase), int'(expPh));
      if (Y_valid) begin
        capY.push_back(int'($signed(Y)));
        capPh.push_back(int'(Y_phase));
      end
    end
    prevAccept = 0;
    if (reset) begin
      hist.delete();
      for (int d = 1; d <= 3; d++) dueV[cyc + d] = 0;
      prevReset = 1;
      enabled = 1;
    end else begin
      prevReset = 0;
      if (enabled && X_valid && expR) begin
        hist.push_front(int'(X));
        if (hist.size() > 11) void'(hist.pop_back());
        dueV[cyc + 2] = 1; dueY[cyc + 2] = modelOut(0); dueP[cyc + 2] = 0;
        dueV[cyc + 3] = 1; dueY[cyc + 3] = modelOut(1); dueP[cyc + 3] = 1;
        prevAccept = 1;
      end
    end
    cyc++;
  end

  task automatic applyStimulus(input bit rst, input bit v, input logic signed [WI-1:0] x);
    @(posedge clk);
    #1;
    reset   = rst;
    X_valid = v;
    X       = x;
  endtask

  // Full-rate pair: a sample on the ready cycle, random junk on the not-ready cycle.
  task automatic offer(input logic signed [WI-1:0] x);
    applyStimulus(0, 1, x);
    applyStimulus(0, 1, WI'($urandom));
  endtask

  task automatic drain();
    repeat (5) applyStimulus(0, 0, WI'($urandom));
  endtask

  task automatic impulseCheck(input string name);
    checkOutput({name, "_count"}, capY.size(), 22);
    for (int j = 0; j < 22 && j < capY.size(); j++) begin
      checkOutput(name, capY[j], (j < 21) ? h[j] : 0);
      checkOutput({name, "_phase"}, capPh[j], j % 2);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);

    capY.delete(); capPh.delete();
    offer(1);
    repeat (10) offer(0);
    drain();
    impulseCheck("impulse");

    capY.delete(); capPh.delete();
    offer(-128);
    repeat (10) offer(0);
    drain();
    checkOutput("neg_count", capY.size(), 22);
    if (capY.size() == 22) begin
      checkOutput("neg_j0", capY[0], 128);
      checkOutput("neg_j2", capY[2], -512);
      checkOutput("neg_j3", capY[3], -1152);
      checkOutput("neg_j10", capY[10], -31872);
      checkOutput("neg_j21", capY[21], 0);
    end

    capY.delete(); capPh.delete();
    repeat (14) offer(127);
    drain();
    checkOutput("step_count", capY.size(), 28);
    for (int j = 20; j < capY.size(); j++) checkOutput("step_pos", capY[j], 50546);
    capY.delete(); capPh.delete();
    repeat (14) offer(-128);
    drain();
    for (int j = 20; j < capY.size(); j++) checkOutput("step_neg", capY[j], -50944);

    capY.delete(); capPh.delete();
    applyStimulus(0, 1, WI'($urandom));
    repeat (5) applyStimulus(0, 0, WI'($urandom));
    checkOutput("gap_count", capY.size(), 2);

    capY.delete(); capPh.delete();
    offer(1);
    offer(0);
    offer(0);
    applyStimulus(0, 1, 0);
    applyStimulus(1, 1, 55);
    applyStimulus(0, 0, 0);
    @(negedge clk);
    checkOutput("rst_Y", int'($signed(Y)), 0);
    checkOutput("rst_Y_valid", int'(Y_valid), 0);
    checkOutput("rst_X_ready", int'(X_ready), 1);
    checkOutput("rst_prior_count", capY.size(), 6);
    capY.delete(); capPh.delete();
    offer(1);
    repeat (10) offer(0);
    drain();
    impulseCheck("post_reset_impulse");

    repeat (400) begin
      applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 6), WI'($urandom));
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/polyphase_interp_2.md
# polyphase_interp_2

Two-phase polyphase interpolate-by-2 FIR filter, the upsampling counterpart of the team's decimate-by-2 FIR. It accepts one signed input sample per handshake and emits two filtered output samples, even phase then odd phase. It uses the shared 21-tap coefficient set split into an 11-tap even sub-filter and a 10-tap odd sub-filter. It sits on the synthesis side of the polyphase chain, driving downstream high-rate stages.

## Interface
- word_size_in, 8, bit-size of input X (two's complement)
- word_size_out, 20, bit-size of output Y (two's complement); covers full-scale gain
- clk  input  1  sole clock, rising edge
- reset  input  1  synchronous, active-high reset; the clock and the synchronous active-high polarity are fixed
- X_valid  input  1  X carries a sample this cycle
- X_ready  output  1  block can accept X this cycle (combinational from state)
- X  input  word_size_in  input sample
- Y_valid  output  1  Y holds a new output sample this cycle
- Y_phase  output  1  0 = even-phase sample, 1 = odd-phase sample
- Y  output  word_size_out  output sample

## Operation
- Coefficients h[0..20]: -1,0,4,9,3,-19,-37,-16,64,174,249,237,147,39,-27,-35,-12,6,9,3,-1.
- Even sub-filter E[k]=h[2k], k=0..10: -1,4,3,-37,64,249,147,-27,-12,9,-1.
- Odd sub-filter O[k]=h[2k+1], k=0..9: 0,9,-19,-16,174,237,39,-35,6,3.
- Delay line d[0..10] of word_size_in signed registers. On accept, d[0]<=X and d[k]<=d[k-1].
- Output computation: y_even = sum E[k]*d[k], y_odd = sum O[k]*d[k].
- Multiplies are shift-add constant multiplies; no generic multipliers. Terms are sign-extended to word_size_out.
- Sums are exact. Worst case is |X|=128 times sum|E| of 554, giving 70912, which is below 2^19. No saturation is needed and no wrap is permitted.
- FSM states are IDLE, EVEN and ODD.
  - IDLE: X_ready=1. On accept, go to EVEN.
  - EVEN: X_ready=0. Register Y<=y_even, Y_phase<=0, Y_valid<=1. Go to ODD.
  - ODD: X_ready=1. Register Y<=y_odd, Y_phase<=1, Y_valid<=1. On accept in the same cycle go to EVEN, else go to IDLE.
- y_odd registered in ODD uses the delay line contents before that cycle's accept (non-blocking update).
- Accept condition is X_valid & X_ready. X is ignored when X_ready=0.
- Output has no backpressure. The consumer must take every Y_valid cycle.
- When Y_valid=0, Y and Y_phase hold their last values.

## Timing
- Reset (synchronous, active-high) produces: state=IDLE, every d[k]=0, Y=0, Y_valid=0, Y_phase=0.
- X_ready is forced to 0 while reset=1, so no accept can occur during reset.
- Accept at cycle t:
  - Y_valid=1, Y_phase=0 (even sample) is visible at t+2.
  - Y_valid=1, Y_phase=1 (odd sample) is visible at t+3.
- Maximum throughput is 1 input per 2 cycles. With X_valid held high, X_ready toggles 1,0,1,0 and Y_valid stays 1 continuously.
- Reset asserted mid-sequence (EVEN or ODD) aborts it. The pending output is discarded and Y_valid=0 on the next cycle. The delay line clears, so filter history restarts from zero.
- An input gap leaves the FSM in IDLE with Y_valid=0. History is retained; the next output uses the full previous delay-line contents.

## Test plan
- Impulse: X=1 accepted once, then X=0 inputs at full rate. Y over 22 outputs must equal h[0..20] in order, i.e. -1,0,4,9,3,-19,... (the last slot is O[10] implicit 0). Y_phase must alternate 0,1.
- Negative impulse: X=-128 once, then zeros. Outputs must equal -128*h[j]: 128,0,-512,-1152,...,peak -31872 at j=10.
- Full-scale step: X=127 held at full rate. After 11 inputs, every even and every odd output must be 50546; the step of -128 must settle at -50944. No overflow is allowed.
- Handshake: X_valid stuck at 1.
  - X_ready must follow 1,0,1,0.
  - Data offered on X_ready=0 cycles must not enter the delay line.
  - Y_valid must stay 1 from the first even output onward.
- Gapped input: single accept, then X_valid=0 for 5 cycles. Required sequence: Y_valid pulses at t+2 (phase 0) and t+3 (phase 1), then Y_valid=0 with Y held at the odd value, and the FSM back in IDLE.
- Reset mid-stream: after 5 impulse-response outputs, assert reset for 1 cycle while in EVEN. Next cycle: Y=0, Y_valid=0, X_ready=1. A fresh impulse must reproduce the exact h sequence, with no residue from earlier history.
